// File: rtl/mips_exec_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS32 sequencer, decoder and execute unit.
package codes;

    typedef logic [31:0] size_t;
    typedef logic [4:0]  regaddr_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'h00,
        FN_SRL   = 6'h02,
        FN_SRA   = 6'h03,
        FN_SLLV  = 6'h04,
        FN_SRLV  = 6'h06,
        FN_SRAV  = 6'h07,
        FN_JR    = 6'h08,
        FN_JALR  = 6'h09,
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_ADDU  = 6'h21,
        FN_SUBU  = 6'h23,
        FN_AND   = 6'h24,
        FN_OR    = 6'h25,
        FN_XOR   = 6'h26,
        FN_NOR   = 6'h27,
        FN_SLT   = 6'h2A,
        FN_SLTU  = 6'h2B
    } func_t;

    typedef enum logic [4:0] {
        RI_BLTZ = 5'h00,
        RI_BGEZ = 5'h01
    } regimm_t;

    localparam logic [1:0] REGFILE_ADDR_SEL_RD    = 2'd0;
    localparam logic [1:0] REGFILE_ADDR_SEL_RT    = 2'd1;
    localparam logic [1:0] REGFILE_ADDR_SEL_GPR31 = 2'd2;

endpackage

// File: rtl/mips_exec_ctrl_exec_state_seq.sv
// FETCH/EXEC/MEM/HALT sequencer; HALT is left only through reset.
module exec_state_seq
    import codes::*;
(
    input  logic       clk,
    input  logic       reset_i,
    input  logic       halt_i,
    input  logic       stall_i,
    input  logic       is_mem_i,
    output logic [1:0] state_o
);

    state_t state;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state <= FETCH;
        end else if (state == HALT) begin
            state <= HALT;
        end else if (state == FETCH && halt_i) begin
            state <= HALT;
        end else if (!stall_i) begin
            case (state)
                FETCH:   state <= EXEC;
                EXEC:    state <= is_mem_i ? MEM : FETCH;
                MEM:     state <= FETCH;
                default: state <= HALT;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: rtl/mips_exec_ctrl.sv
// Multi-cycle MIPS32 control: sequencer, per-state enable decode, ALU, branch unit and HI/LO.
module mips_exec_ctrl
    import codes::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        halt_i,
    input  logic        stall_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  regimm_i,
    input  logic [4:0]  shift_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [15:0] immediate_i,
    input  logic [25:0] target_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ram_readdata_i,
    output logic [1:0]  state_o,
    output logic        pc_write_en_o,
    output logic        ir_write_en_o,
    output logic        ram_write_en_o,
    output logic        ram_read_en_o,
    output logic [3:0]  ram_byte_en_o,
    output logic        ram_addr_sel_o,
    output logic        src_b_sel_o,
    output logic        regfile_write_en_o,
    output logic [1:0]  regfile_addr_3_sel_o,
    output logic [31:0] rd_o,
    output logic [31:0] rt_o,
    output logic [31:0] effective_address_o,
    output logic        b_cond_met_o,
    output logic [31:0] target_addr_o,
    output logic [31:0] mfhi_o,
    output logic [31:0] mflo_o
);

    size_t  hi, lo, sext, zext, link, branch_target, rd_res, rt_res, jump_target;
    logic   rtype_wr, itype_wr, is_load, is_store, is_jal, is_jalr, branch_taken;
    state_t state;
    logic [1:0] state_raw;

    exec_state_seq u_seq (
        .clk      (clk),
        .reset_i  (reset_i),
        .halt_i   (halt_i),
        .stall_i  (stall_i),
        .is_mem_i (is_load | is_store),
        .state_o  (state_raw)
    );

    assign state   = state_t'(state_raw);
    assign state_o = state_raw;

    assign sext                = {{16{immediate_i[15]}}, immediate_i};
    assign zext                = {16'h0000, immediate_i};
    assign link                = pc_i + 32'd8;
    assign branch_target       = pc_i + 32'd4 + {sext[29:0], 2'b00};
    assign effective_address_o = rs_i + sext;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        rtype_wr     = 1'b0;
        itype_wr     = 1'b0;
        is_load      = 1'b0;
        is_store     = 1'b0;
        is_jal       = 1'b0;
        is_jalr      = 1'b0;
        branch_taken = 1'b0;
        rd_res       = '0;
        rt_res       = '0;
        jump_target  = branch_target;
        case (opcode_i)
            OP_SPECIAL: begin
                rtype_wr = 1'b1;
                case (funct_i)
                    FN_ADDU: rd_res = rs_i + rt_i;
                    FN_SUBU: rd_res = rs_i - rt_i;
                    FN_AND:  rd_res = rs_i & rt_i;
                    FN_OR:   rd_res = rs_i | rt_i;
                    FN_XOR:  rd_res = rs_i ^ rt_i;
                    FN_NOR:  rd_res = ~(rs_i | rt_i);
                    FN_SLT:  rd_res = {31'b0, $signed(rs_i) < $signed(rt_i)};
                    FN_SLTU: rd_res = {31'b0, rs_i < rt_i};
                    FN_SLL:  rd_res = rt_i << shift_i;
                    FN_SRL:  rd_res = rt_i >> shift_i;
                    FN_SRA:  rd_res = $signed(rt_i) >>> shift_i;
                    FN_SLLV: rd_res = rt_i << rs_i[4:0];
                    FN_SRLV: rd_res = rt_i >> rs_i[4:0];
                    FN_SRAV: rd_res = $signed(rt_i) >>> rs_i[4:0];
                    FN_MFHI: rd_res = hi;
                    FN_MFLO: rd_res = lo;
                    FN_JR: begin
                        rtype_wr     = 1'b0;
                        branch_taken = 1'b1;
                        jump_target  = rs_i;
                    end
                    FN_JALR: begin
                        rtype_wr     = 1'b0;
                        is_jalr      = 1'b1;
                        branch_taken = 1'b1;
                        jump_target  = rs_i;
                        rd_res       = link;
                    end
                    default: rtype_wr = 1'b0;
                endcase
            end
            OP_ADDIU: begin itype_wr = 1'b1; rt_res = rs_i + sext; end
            OP_SLTI:  begin itype_wr = 1'b1; rt_res = {31'b0, $signed(rs_i) < $signed(sext)}; end
            OP_SLTIU: begin itype_wr = 1'b1; rt_res = {31'b0, rs_i < sext}; end
            OP_ANDI:  begin itype_wr = 1'b1; rt_res = rs_i & zext; end
            OP_ORI:   begin itype_wr = 1'b1; rt_res = rs_i | zext; end
            OP_XORI:  begin itype_wr = 1'b1; rt_res = rs_i ^ zext; end
            OP_LUI:   begin itype_wr = 1'b1; rt_res = {immediate_i, 16'h0000}; end
            OP_LW:    is_load  = 1'b1;
            OP_SW:    is_store = 1'b1;
            OP_BEQ:   branch_taken = (rs_i == rt_i);
            OP_BNE:   branch_taken = (rs_i != rt_i);
            OP_REGIMM: begin
                if (regimm_i == RI_BLTZ)      branch_taken = rs_i[31];
                else if (regimm_i == RI_BGEZ) branch_taken = ~rs_i[31];
            end
            OP_J: begin
                branch_taken = 1'b1;
                jump_target  = {pc_i[31:28], target_i, 2'b00};
            end
            OP_JAL: begin
                is_jal       = 1'b1;
                branch_taken = 1'b1;
                jump_target  = {pc_i[31:28], target_i, 2'b00};
                rd_res       = link;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        ram_write_en_o       = 1'b0;
        ram_read_en_o        = 1'b0;
        ram_byte_en_o        = 4'h0;
        ram_addr_sel_o       = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_write_en_o   = 1'b0;
        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
        b_cond_met_o         = 1'b0;
        rt_o                 = rt_res;
        case (state)
            FETCH: begin
                ram_read_en_o = 1'b1;
                ir_write_en_o = 1'b1;
                ram_byte_en_o = 4'hF;
            end
            EXEC: begin
                pc_write_en_o      = ~(is_load | is_store);
                regfile_write_en_o = rtype_wr | itype_wr | is_jal | is_jalr;
                b_cond_met_o       = branch_taken;
                if (itype_wr) begin
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
                    src_b_sel_o          = 1'b1;
                end else if (is_jal) begin
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_GPR31;
                end
            end
            MEM: begin
                pc_write_en_o  = 1'b1;
                ram_addr_sel_o = 1'b1;
                ram_byte_en_o  = 4'hF;
                if (is_load) begin
                    ram_read_en_o        = 1'b1;
                    regfile_write_en_o   = 1'b1;
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
                    rt_o                 = ram_readdata_i;
                end else begin
                    ram_write_en_o = 1'b1;
                    rt_o           = rt_i;
                end
            end
            default: ;
        endcase
    end

    assign rd_o          = rd_res;
    assign target_addr_o = jump_target;

    // HI/LO update on the edge that leaves EXEC, never while the bus stalls.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            hi <= '0;
            lo <= '0;
        end else if (state == EXEC && !stall_i && opcode_i == OP_SPECIAL) begin
            case (funct_i)
                FN_MULT:  {hi, lo} <= {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
                FN_MULTU: {hi, lo} <= {32'h0, rs_i} * {32'h0, rt_i};
                FN_MTHI:  hi <= rs_i;
                FN_MTLO:  lo <= rs_i;
                default: ;
            endcase
        end
    end

    assign mfhi_o = hi;
    assign mflo_o = lo;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed-vector bench for mips_exec_ctrl with hand-computed expected values.
module tb_mips_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset_i, halt_i, stall_i;
    logic [5:0]  opcode_i, funct_i;
    logic [4:0]  regimm_i, shift_i;
    logic [31:0] rs_i, rt_i, pc_i, ram_readdata_i;
    logic [15:0] immediate_i;
    logic [25:0] target_i;
    logic [1:0]  state_o, regfile_addr_3_sel_o;
    logic        pc_write_en_o, ir_write_en_o, ram_write_en_o, ram_read_en_o;
    logic [3:0]  ram_byte_en_o;
    logic        ram_addr_sel_o, src_b_sel_o, regfile_write_en_o, b_cond_met_o;
    logic [31:0] rd_o, rt_o, effective_address_o, target_addr_o, mfhi_o, mflo_o;

    int n_vec = 0;
    int n_err = 0;

    mips_exec_ctrl dut (
        .clk(clk), .reset_i(reset_i), .halt_i(halt_i), .stall_i(stall_i),
        .opcode_i(opcode_i), .funct_i(funct_i), .regimm_i(regimm_i), .shift_i(shift_i),
        .rs_i(rs_i), .rt_i(rt_i), .immediate_i(immediate_i), .target_i(target_i),
        .pc_i(pc_i), .ram_readdata_i(ram_readdata_i), .state_o(state_o),
        .pc_write_en_o(pc_write_en_o), .ir_write_en_o(ir_write_en_o),
        .ram_write_en_o(ram_write_en_o), .ram_read_en_o(ram_read_en_o),
        .ram_byte_en_o(ram_byte_en_o), .ram_addr_sel_o(ram_addr_sel_o),
        .src_b_sel_o(src_b_sel_o), .regfile_write_en_o(regfile_write_en_o),
        .regfile_addr_3_sel_o(regfile_addr_3_sel_o), .rd_o(rd_o), .rt_o(rt_o),
        .effective_address_o(effective_address_o), .b_cond_met_o(b_cond_met_o),
        .target_addr_o(target_addr_o), .mfhi_o(mfhi_o), .mflo_o(mflo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input logic [31:0] pc);
        opcode_i = op; funct_i = fn; rs_i = rs; rt_i = rt; immediate_i = imm; pc_i = pc;
    endtask

    task automatic test_reset();
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_vec++; if (mfhi_o !== 32'h0 || mflo_o !== 32'h0) begin
            n_err++; $display("FAIL reset_hilo: got %h/%h want 0/0", mfhi_o, mflo_o); end
        n_vec++; if ({ir_write_en_o, ram_read_en_o, ram_addr_sel_o, ram_byte_en_o, pc_write_en_o, regfile_write_en_o} !== 9'b110_1111_00) begin
            n_err++; $display("FAIL reset_fetch_enables: got ir=%b rd=%b as=%b be=%h pc=%b rf=%b",
                ir_write_en_o, ram_read_en_o, ram_addr_sel_o, ram_byte_en_o, pc_write_en_o, regfile_write_en_o); end
    endtask

    task automatic test_addu();
        set_instr(6'h00, 6'h21, 32'hFFFF_FFFF, 32'h2, 16'h0, 32'h0);
        n_vec++; if (b_cond_met_o !== 1'b0) begin n_err++; $display("FAIL addu_fetch_cond: got %b want 0", b_cond_met_o); end
        tick();
        n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL addu_state_exec: got %0d want 1", state_o); end
        n_vec++; if (rd_o !== 32'h1) begin n_err++; $display("FAIL addu_rd: got %h want 00000001", rd_o); end
        n_vec++; if ({regfile_write_en_o, regfile_addr_3_sel_o, pc_write_en_o, src_b_sel_o} !== 5'b1_00_1_0) begin
            n_err++; $display("FAIL addu_ctrl: got rf=%b sel=%0d pc=%b srcb=%b want 1/0/1/0",
                regfile_write_en_o, regfile_addr_3_sel_o, pc_write_en_o, src_b_sel_o); end
        tick();
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL addu_state_fetch: got %0d want 0", state_o); end
    endtask

    task automatic test_itype();
        set_instr(6'h0A, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h0001, 32'h0);
        tick();
        n_vec++; if (rt_o !== 32'h1) begin n_err++; $display("FAIL slti_rt: got %h want 00000001", rt_o); end
        n_vec++; if ({regfile_write_en_o, regfile_addr_3_sel_o, src_b_sel_o} !== 4'b1_01_1) begin
            n_err++; $display("FAIL slti_ctrl: got rf=%b sel=%0d srcb=%b want 1/1/1",
                regfile_write_en_o, regfile_addr_3_sel_o, src_b_sel_o); end
        opcode_i = 6'h0B;
        #1;
        n_vec++; if (rt_o !== 32'h0) begin n_err++; $display("FAIL sltiu_rt: got %h want 00000000", rt_o); end
        opcode_i = 6'h0F; immediate_i = 16'hBEEF;
        #1;
        n_vec++; if (rt_o !== 32'hBEEF_0000) begin n_err++; $display("FAIL lui_rt: got %h want beef0000", rt_o); end
        set_instr(6'h00, 6'h03, 32'h0, 32'h8000_0000, 16'h0, 32'h0);
        shift_i = 5'd4;
        #1;
        n_vec++; if (rd_o !== 32'hF800_0000) begin n_err++; $display("FAIL sra_rd: got %h want f8000000", rd_o); end
        tick();
    endtask

    task automatic test_mult();
        set_instr(6'h00, 6'h18, 32'hFFFF_FFFE, 32'h3, 16'h0, 32'h0);
        tick(); tick();
        n_vec++; if (mfhi_o !== 32'hFFFF_FFFF || mflo_o !== 32'hFFFF_FFFA) begin
            n_err++; $display("FAIL mult_hilo: got %h/%h want ffffffff/fffffffa", mfhi_o, mflo_o); end
        funct_i = 6'h19;
        tick(); tick();
        n_vec++; if (mfhi_o !== 32'h2 || mflo_o !== 32'hFFFF_FFFA) begin
            n_err++; $display("FAIL multu_hilo: got %h/%h want 00000002/fffffffa", mfhi_o, mflo_o); end
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL multu_state: got %0d want 0", state_o); end
    endtask

    task automatic test_lw_sw();
        set_instr(6'h23, 6'h00, 32'h0000_1000, 32'h0, 16'hFFFC, 32'h0);
        ram_readdata_i = 32'hDEAD_BEEF;
        tick();
        n_vec++; if (effective_address_o !== 32'h0000_0FFC) begin
            n_err++; $display("FAIL lw_ea: got %h want 00000ffc", effective_address_o); end
        n_vec++; if (pc_write_en_o !== 1'b0 || regfile_write_en_o !== 1'b0) begin
            n_err++; $display("FAIL lw_exec_ctrl: got pc=%b rf=%b want 0/0", pc_write_en_o, regfile_write_en_o); end
        tick();
        n_vec++; if (state_o !== 2'd2) begin n_err++; $display("FAIL lw_state_mem: got %0d want 2", state_o); end
        n_vec++; if ({ram_read_en_o, ram_addr_sel_o, regfile_write_en_o, regfile_addr_3_sel_o, pc_write_en_o, ram_write_en_o} !== 7'b1_1_1_01_1_0) begin
            n_err++; $display("FAIL lw_mem_ctrl: got rd=%b as=%b rf=%b sel=%0d pc=%b wr=%b",
                ram_read_en_o, ram_addr_sel_o, regfile_write_en_o, regfile_addr_3_sel_o, pc_write_en_o, ram_write_en_o); end
        n_vec++; if (rt_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_rt: got %h want deadbeef", rt_o); end
        tick();
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL lw_state_fetch: got %0d want 0", state_o); end
        set_instr(6'h2B, 6'h00, 32'h0000_2000, 32'h1234_5678, 16'h0010, 32'h0);
        tick(); tick();
        n_vec++; if ({ram_write_en_o, ram_read_en_o, ram_addr_sel_o, ram_byte_en_o, regfile_write_en_o, pc_write_en_o} !== 9'b1_0_1_1111_0_1) begin
            n_err++; $display("FAIL sw_mem_ctrl: got wr=%b rd=%b as=%b be=%h rf=%b pc=%b",
                ram_write_en_o, ram_read_en_o, ram_addr_sel_o, ram_byte_en_o, regfile_write_en_o, pc_write_en_o); end
        n_vec++; if (rt_o !== 32'h1234_5678 || effective_address_o !== 32'h0000_2010) begin
            n_err++; $display("FAIL sw_data: got rt=%h ea=%h want 12345678/00002010", rt_o, effective_address_o); end
        tick();
    endtask

    task automatic test_branch();
        set_instr(6'h05, 6'h00, 32'h1, 32'h2, 16'h0003, 32'h0000_0100);
        tick();
        n_vec++; if (b_cond_met_o !== 1'b1 || target_addr_o !== 32'h0000_0110) begin
            n_err++; $display("FAIL bne: got cond=%b tgt=%h want 1/00000110", b_cond_met_o, target_addr_o); end
        opcode_i = 6'h04;
        #1;
        n_vec++; if (b_cond_met_o !== 1'b0) begin n_err++; $display("FAIL beq: got cond=%b want 0", b_cond_met_o); end
        tick();
        n_vec++; if (b_cond_met_o !== 1'b0) begin n_err++; $display("FAIL branch_fetch_cond: got %b want 0", b_cond_met_o); end
        set_instr(6'h03, 6'h00, 32'h0, 32'h0, 16'h0, 32'h4000_0010);
        target_i = 26'h000_0100;
        tick();
        n_vec++; if (b_cond_met_o !== 1'b1 || target_addr_o !== 32'h4000_0400 || rd_o !== 32'h4000_0018) begin
            n_err++; $display("FAIL jal: got cond=%b tgt=%h link=%h want 1/40000400/40000018", b_cond_met_o, target_addr_o, rd_o); end
        n_vec++; if (regfile_write_en_o !== 1'b1 || regfile_addr_3_sel_o !== 2'd2) begin
            n_err++; $display("FAIL jal_ctrl: got rf=%b sel=%0d want 1/2", regfile_write_en_o, regfile_addr_3_sel_o); end
        tick();
        set_instr(6'h01, 6'h00, 32'h8000_0000, 32'h0, 16'hFFFF, 32'h0000_0200);
        regimm_i = 5'h00;
        tick();
        n_vec++; if (b_cond_met_o !== 1'b1 || target_addr_o !== 32'h0000_0200) begin
            n_err++; $display("FAIL bltz: got cond=%b tgt=%h want 1/00000200", b_cond_met_o, target_addr_o); end
        tick();
        set_instr(6'h3F, 6'h00, 32'h5, 32'h5, 16'h0, 32'h0);
        tick();
        n_vec++; if ({pc_write_en_o, regfile_write_en_o, ram_write_en_o, b_cond_met_o} !== 4'b1000) begin
            n_err++; $display("FAIL unknown_op: got pc=%b rf=%b wr=%b cond=%b want 1/0/0/0",
                pc_write_en_o, regfile_write_en_o, ram_write_en_o, b_cond_met_o); end
        tick();
    endtask

    task automatic test_stall();
        set_instr(6'h00, 6'h18, 32'h5, 32'h7, 16'h0, 32'h0);
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (state_o !== 2'd1 || mfhi_o !== 32'h2 || mflo_o !== 32'hFFFF_FFFA) begin
                n_err++; $display("FAIL stall_hold[%0d]: got st=%0d hilo=%h/%h want 1 00000002/fffffffa",
                    i, state_o, mfhi_o, mflo_o); end
        end
        stall_i = 1'b0;
        tick();
        n_vec++; if (state_o !== 2'd0 || mfhi_o !== 32'h0 || mflo_o !== 32'h23) begin
            n_err++; $display("FAIL stall_release: got st=%0d hilo=%h/%h want 0 00000000/00000023", state_o, mfhi_o, mflo_o); end
    endtask

    task automatic test_reset_mid_exec();
        set_instr(6'h00, 6'h21, 32'h1, 32'h1, 16'h0, 32'h0);
        tick();
        #2 reset_i = 1'b0;
        #1;
        n_vec++; if (state_o !== 2'd0 || mfhi_o !== 32'h0 || mflo_o !== 32'h0) begin
            n_err++; $display("FAIL reset_mid_exec: got st=%0d hilo=%h/%h want 0 0/0", state_o, mfhi_o, mflo_o); end
        #1 reset_i = 1'b1;
        #1;
        n_vec++; if (ir_write_en_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ir: got %b want 1", ir_write_en_o); end
    endtask

    task automatic test_halt();
        set_instr(6'h00, 6'h21, 32'h1, 32'h1, 16'h0, 32'h0);
        halt_i  = 1'b1;
        stall_i = 1'b1;
        tick();
        halt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stall_i = i[0];
            n_vec++; if (state_o !== 2'd3 || {pc_write_en_o, ir_write_en_o, ram_write_en_o, ram_read_en_o,
                         ram_byte_en_o, regfile_write_en_o, b_cond_met_o} !== 10'b0) begin
                n_err++; $display("FAIL halt_hold[%0d]: got st=%0d pc=%b ir=%b wr=%b rd=%b be=%h rf=%b", i, state_o,
                    pc_write_en_o, ir_write_en_o, ram_write_en_o, ram_read_en_o, ram_byte_en_o, regfile_write_en_o); end
            tick();
        end
    endtask

    initial begin
        reset_i = 1'b0; halt_i = 1'b0; stall_i = 1'b0;
        opcode_i = 6'h3F; funct_i = 6'h0; regimm_i = 5'h0; shift_i = 5'h0;
        rs_i = 32'h0; rt_i = 32'h0; immediate_i = 16'h0; target_i = 26'h0;
        pc_i = 32'h0; ram_readdata_i = 32'h0;
        #22 reset_i = 1'b1;
        #2;
        test_reset();
        test_addu();
        test_itype();
        test_mult();
        test_lw_sw();
        test_branch();
        test_stall();
        test_reset_mid_exec();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
